// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the pattern_pwm command loader.
package pwm_cfg_pkg;

  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned DESSERT_W = 16;
  localparam int unsigned PNUM_W    = 8;

  localparam logic [3:0] OP_NOP         = 4'h0;
  localparam logic [3:0] OP_SET_TIMING  = 4'h1;
  localparam logic [3:0] OP_SET_PATTERN = 4'h2;
  localparam logic [3:0] OP_START       = 4'h3;
  localparam logic [3:0] OP_STOP        = 4'h4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_BAD_CH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT_IDLE,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/pwm_cfg_loader.sv
// Decodes received command packets into per-channel shadow registers and
// commits them to the active pattern_pwm configuration once a channel is idle.
module pwm_cfg_loader
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned PAT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      recv_done,
  input  logic [7:0]                dataA,
  input  logic [15:0]               dataB,
  input  logic [15:0]               dataC,
  input  logic [7:0]                dataD,
  input  logic [N_CH-1:0]           ch_busy,
  output logic [N_CH-1:0]           pwm_en,
  output logic [N_CH*DUTY_W-1:0]    duty_num,
  output logic [N_CH*DESSERT_W-1:0] pulse_dessert,
  output logic [N_CH*PNUM_W-1:0]    pulse_num,
  output logic [N_CH*PAT_W-1:0]     pat,
  output logic                      cfg_ack,
  output logic                      cmd_err,
  output logic [1:0]                err_code,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      CH_LIMIT = 4'(N_CH);

  state_t           state_q, state_d;
  logic [3:0]       op_q, ch_q;
  logic [15:0]      b_q, c_q;
  logic [7:0]       d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_CH-1:0]  ch_sel;

  logic       accept, drop;
  logic       wr_timing, wr_pattern, do_stop, do_commit;
  logic       raise_err, cnt_clr, cnt_inc;
  logic [1:0] err_val;

  always_comb begin
    ch_sel = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      ch_sel[k] = (ch_q == 4'(k));
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = recv_done && (state_q == ST_IDLE);
    drop       = recv_done && (state_q != ST_IDLE);
    wr_timing  = 1'b0;
    wr_pattern = 1'b0;
    do_stop    = 1'b0;
    do_commit  = 1'b0;
    raise_err  = 1'b0;
    err_val    = ERR_NONE;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (recv_done) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        // A bad channel index is rejected before the opcode is considered.
        if (op_q != OP_NOP && ch_q >= CH_LIMIT) begin
          raise_err = 1'b1;
          err_val   = ERR_BAD_CH;
        end else begin
          case (op_q)
            OP_NOP:         ;
            OP_SET_TIMING:  wr_timing  = 1'b1;
            OP_SET_PATTERN: wr_pattern = 1'b1;
            OP_START: begin
              state_d = ST_WAIT_IDLE;
              cnt_clr = 1'b1;
            end
            OP_STOP:        do_stop    = 1'b1;
            default: begin
              raise_err = 1'b1;
              err_val   = ERR_BAD_OP;
            end
          endcase
        end
      end
      ST_WAIT_IDLE: begin
        if ((ch_busy & ch_sel) == '0) begin
          state_d = ST_COMMIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          raise_err = 1'b1;
          err_val   = ERR_TIMEOUT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ch_q     <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      cfg_ack  <= 1'b0;
      cmd_err  <= 1'b0;
      err_code <= ERR_NONE;
      drop_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= dataA[7:4];
        ch_q <= dataA[3:0];
        b_q  <= dataB;
        c_q  <= dataC;
        d_q  <= dataD;
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      cfg_ack <= do_commit;
      cmd_err <= raise_err;
      if (raise_err) err_code <= err_val;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [DUTY_W-1:0]    sh_duty, act_duty;
    logic [DESSERT_W-1:0] sh_dessert, act_dessert;
    logic [PNUM_W-1:0]    sh_pnum, act_pnum;
    logic [PAT_W-1:0]     sh_pat, act_pat;
    logic                 en_q;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sh_duty     <= DUTY_W'(1);
        sh_dessert  <= DESSERT_W'(1);
        sh_pnum     <= '0;
        sh_pat      <= PAT_W'(1);
        act_duty    <= DUTY_W'(1);
        act_dessert <= DESSERT_W'(1);
        act_pnum    <= '0;
        act_pat     <= PAT_W'(1);
        en_q        <= 1'b0;
      end else if (ch_sel[k]) begin
        if (wr_timing) begin
          sh_duty    <= b_q[DUTY_W-1:0];
          sh_dessert <= c_q;
        end
        if (wr_pattern) begin
          sh_pat  <= b_q[PAT_W-1:0];
          sh_pnum <= d_q;
        end
        if (do_stop) en_q <= 1'b0;
        if (do_commit) begin
          act_duty    <= sh_duty;
          act_dessert <= sh_dessert;
          act_pnum    <= sh_pnum;
          act_pat     <= sh_pat;
          en_q        <= 1'b1;
        end
      end
    end

    assign pwm_en[k]                             = en_q;
    assign duty_num[k*DUTY_W +: DUTY_W]          = act_duty;
    assign pulse_dessert[k*DESSERT_W +: DESSERT_W] = act_dessert;
    assign pulse_num[k*PNUM_W +: PNUM_W]         = act_pnum;
    assign pat[k*PAT_W +: PAT_W]                 = act_pat;
  end

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Self-checking bench for pwm_cfg_loader against a command-level reference model.
module tb_pwm_cfg_loader;

  localparam int unsigned N_CH    = 2;
  localparam int unsigned PAT_W   = 16;
  localparam int unsigned T       = 16;
  localparam int unsigned K_WATCH = T + 6;
  localparam int unsigned BW      = N_CH * (1 + 8 + 16 + 8 + PAT_W);

  logic                  sys_clk = 1'b0;
  logic                  sys_rst = 1'b1;
  logic                  recv_done = 1'b0;
  logic [7:0]            dataA = '0;
  logic [15:0]           dataB = '0;
  logic [15:0]           dataC = '0;
  logic [7:0]            dataD = '0;
  logic [N_CH-1:0]       ch_busy = '0;
  logic [N_CH-1:0]       pwm_en;
  logic [N_CH*8-1:0]     duty_num;
  logic [N_CH*16-1:0]    pulse_dessert;
  logic [N_CH*8-1:0]     pulse_num;
  logic [N_CH*PAT_W-1:0] pat;
  logic                  cfg_ack, cmd_err;
  logic [1:0]            err_code;
  logic [7:0]            drop_cnt;

  pwm_cfg_loader #(.N_CH(N_CH), .PAT_W(PAT_W), .TIMEOUT_CYC(T)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .recv_done(recv_done),
    .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataD(dataD),
    .ch_busy(ch_busy), .pwm_en(pwm_en), .duty_num(duty_num),
    .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .pat(pat),
    .cfg_ack(cfg_ack), .cmd_err(cmd_err), .err_code(err_code), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: shadow/active banks per channel, plus status.
  logic [7:0]       m_sh_duty [N_CH], m_act_duty [N_CH];
  logic [15:0]      m_sh_des  [N_CH], m_act_des  [N_CH];
  logic [7:0]       m_sh_pn   [N_CH], m_act_pn   [N_CH];
  logic [PAT_W-1:0] m_sh_pat  [N_CH], m_act_pat  [N_CH];
  logic             m_en      [N_CH];
  int unsigned      m_drop;
  logic [1:0]       m_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outcome of the latest command (0 none, 1 ack, 2 error).
  int unsigned   exp_kind, exp_k;
  logic [1:0]    exp_code;
  logic [BW-1:0] exp_k1;

  int unsigned   ack_k, err_k, n_ack, n_err;
  logic          both, early_chg;
  logic [BW-1:0] obs_k1;
  logic [1:0]    obs_code;

  function automatic logic [BW-1:0] dut_bundle();
    return {pwm_en, duty_num, pulse_dessert, pulse_num, pat};
  endfunction

  function automatic logic [BW-1:0] mdl_bundle();
    logic [N_CH-1:0]       en;
    logic [N_CH*8-1:0]     du;
    logic [N_CH*16-1:0]    de;
    logic [N_CH*8-1:0]     pn;
    logic [N_CH*PAT_W-1:0] pa;
    for (int i = 0; i < N_CH; i++) begin
      en[i]             = m_en[i];
      du[8*i +: 8]      = m_act_duty[i];
      de[16*i +: 16]    = m_act_des[i];
      pn[8*i +: 8]      = m_act_pn[i];
      pa[PAT_W*i +: PAT_W] = m_act_pat[i];
    end
    return {en, du, de, pn, pa};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_sh_duty[i] = 8'd1;  m_act_duty[i] = 8'd1;
      m_sh_des[i]  = 16'd1; m_act_des[i]  = 16'd1;
      m_sh_pn[i]   = 8'd0;  m_act_pn[i]   = 8'd0;
      m_sh_pat[i]  = PAT_W'(1); m_act_pat[i] = PAT_W'(1);
      m_en[i]      = 1'b0;
    end
    m_drop = 0;
    m_err  = 2'd0;
  endtask

  // L = number of wait cycles the target stays busy; n = packets sent while busy.
  task automatic model_cmd(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c,
                           input logic [7:0] d, input int unsigned L, input int unsigned n);
    int unsigned   op, ch;
    logic [BW-1:0] pre;
    op  = int'(a[7:4]);
    ch  = int'(a[3:0]);
    pre = mdl_bundle();
    exp_kind = 0;
    exp_k    = 0;
    exp_code = m_err;
    if (op != 0 && ch >= N_CH) begin
      exp_kind = 2; exp_k = 1; exp_code = 2'd2;
    end else begin
      case (op)
        0: ;
        1: begin m_sh_duty[ch] = b[7:0]; m_sh_des[ch] = c; end
        2: begin m_sh_pat[ch] = b[PAT_W-1:0]; m_sh_pn[ch] = d; end
        3: begin
          if (L >= T) begin
            exp_kind = 2; exp_k = T + 1; exp_code = 2'd3;
          end else begin
            exp_kind = 1; exp_k = L + 3;
            m_act_duty[ch] = m_sh_duty[ch];
            m_act_des[ch]  = m_sh_des[ch];
            m_act_pn[ch]   = m_sh_pn[ch];
            m_act_pat[ch]  = m_sh_pat[ch];
            m_en[ch]       = 1'b1;
          end
        end
        4: m_en[ch] = 1'b0;
        default: begin exp_kind = 2; exp_k = 1; exp_code = 2'd1; end
      endcase
    end
    exp_k1 = (op == 4 && ch < N_CH) ? mdl_bundle() : pre;
    m_err  = exp_code;
    m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [7:0] d, input int unsigned L, input int unsigned n);
    int unsigned     ch;
    logic [N_CH-1:0] busy;
    ch = int'(a[3:0]);
    ack_k = 0; err_k = 0; n_ack = 0; n_err = 0;
    both = 1'b0; early_chg = 1'b0; obs_code = '0; obs_k1 = '0;
    busy = N_CH'($urandom);
    if (ch < N_CH) busy[ch] = (L > 0);
    @(negedge sys_clk);
    ch_busy = busy; recv_done = 1'b1;
    dataA = a; dataB = b; dataC = c; dataD = d;
    @(posedge sys_clk);
    for (int unsigned k = 1; k <= K_WATCH; k++) begin
      @(negedge sys_clk);
      recv_done = (k >= 2 && k - 1 <= n);
      if (recv_done) begin
        dataA = 8'($urandom); dataB = 16'($urandom);
        dataC = 16'($urandom); dataD = 8'($urandom);
      end
      if (ch < N_CH && L > 0 && k == L + 2) ch_busy[ch] = 1'b0;
      @(posedge sys_clk);
      #1;
      if (cfg_ack) begin n_ack++; if (ack_k == 0) ack_k = k; end
      if (cmd_err) begin
        n_err++;
        if (err_k == 0) begin err_k = k; obs_code = err_code; end
      end
      if (cfg_ack && cmd_err) both = 1'b1;
      if (k == 1) obs_k1 = dut_bundle();
      else if (ack_k == 0 && err_k == 0 && dut_bundle() !== obs_k1) early_chg = 1'b1;
    end
    @(negedge sys_clk);
    recv_done = 1'b0;
    ch_busy   = '0;
  endtask

  task automatic do_cmd(input logic [7:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic [7:0] d, input int unsigned L, input int unsigned n);
    model_cmd(a, b, c, d, L, n);
    run_cmd(a, b, c, d, L, n);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_reset();
    @(posedge sys_clk); #1;
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL reset_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
    n_checks++; if (pat[15:0] !== 16'h0001) begin n_fail++; $display("FAIL reset_pat got %h want 0001", pat[15:0]); end
    n_checks++; if (pwm_en !== 2'b00) begin n_fail++; $display("FAIL reset_pwm_en got %b want 00", pwm_en); end
    n_checks++; if ({cfg_ack, cmd_err, err_code, drop_cnt} !== 12'h000) begin n_fail++; $display("FAIL reset_status got %b%b %0d %0d want 0", cfg_ack, cmd_err, err_code, drop_cnt); end
  endtask

  task automatic test_basic_start();
    do_cmd(8'h10, 16'h0005, 16'h0003, 8'h00, 0, 0);
    do_cmd(8'h20, 16'hA5A5, 16'($urandom), 8'h04, 0, 0);
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL basic_shadow_hidden got %h want %h", dut_bundle(), mdl_bundle()); end
    do_cmd(8'h30, 16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
    n_checks++; if (n_ack !== 1 || ack_k !== 3 || exp_k !== 3) begin n_fail++; $display("FAIL basic_ack_cycle got %0d (n=%0d) want 3", ack_k, n_ack); end
    n_checks++; if (n_err !== 0) begin n_fail++; $display("FAIL basic_no_err got %0d want 0", n_err); end
    n_checks++; if ({duty_num[7:0], pulse_dessert[15:0], pat[15:0], pulse_num[7:0], pwm_en[0]} !== {8'd5, 16'd3, 16'hA5A5, 8'd4, 1'b1})
      begin n_fail++; $display("FAIL basic_ch0 got %h %h %h %h %b want 05 0003 a5a5 04 1", duty_num[7:0], pulse_dessert[15:0], pat[15:0], pulse_num[7:0], pwm_en[0]); end
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL basic_all got %h want %h", dut_bundle(), mdl_bundle()); end
  endtask

  task automatic test_timeout();
    do_cmd(8'h31, '0, '0, '0, T, 0);
    n_checks++; if (n_err !== 1 || err_k !== T + 1 || obs_code !== 2'd3) begin n_fail++; $display("FAIL timeout_err got k=%0d n=%0d code=%0d want k=%0d code=3", err_k, n_err, obs_code, T + 1); end
    n_checks++; if (n_ack !== 0 || pwm_en[1] !== 1'b0) begin n_fail++; $display("FAIL timeout_no_commit got ack=%0d en1=%b want 0 0", n_ack, pwm_en[1]); end
    n_checks++; if (err_code !== 2'd3) begin n_fail++; $display("FAIL timeout_code_held got %0d want 3", err_code); end
    do_cmd(8'h31, '0, '0, '0, T - 1, 0);
    n_checks++; if (n_ack !== 1 || ack_k !== T + 2 || n_err !== 0) begin n_fail++; $display("FAIL timeout_edge_commit got k=%0d n=%0d err=%0d want k=%0d", ack_k, n_ack, n_err, T + 2); end
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL timeout_edge_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
  endtask

  task automatic test_wait_busy();
    do_cmd(8'h11, 16'($urandom), 16'($urandom), 8'h00, 0, 0);
    do_cmd(8'h21, 16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
    do_cmd(8'h31, '0, '0, '0, 10, 0);
    n_checks++; if (early_chg !== 1'b0 || obs_k1 !== exp_k1) begin n_fail++; $display("FAIL busy_outputs_held got chg=%b want 0", early_chg); end
    n_checks++; if (n_ack !== 1 || ack_k !== 13) begin n_fail++; $display("FAIL busy_ack_cycle got %0d want 13", ack_k); end
    n_checks++; if (dut_bundle() !== mdl_bundle() || pwm_en[1] !== 1'b1) begin n_fail++; $display("FAIL busy_commit got %h want %h", dut_bundle(), mdl_bundle()); end
  endtask

  task automatic test_errors();
    do_cmd(8'h50, 16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
    n_checks++; if (n_err !== 1 || err_k !== 1 || obs_code !== 2'd1) begin n_fail++; $display("FAIL err_bad_op got k=%0d code=%0d want k=1 code=1", err_k, obs_code); end
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL err_bad_op_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
    do_cmd(8'h12, 16'($urandom), 16'($urandom), 8'($urandom), 0, 0);
    n_checks++; if (n_err !== 1 || err_k !== 1 || obs_code !== 2'd2) begin n_fail++; $display("FAIL err_bad_ch got k=%0d code=%0d want k=1 code=2", err_k, obs_code); end
    n_checks++; if (dut_bundle() !== mdl_bundle() || n_ack !== 0) begin n_fail++; $display("FAIL err_bad_ch_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
    do_cmd(8'h05, '0, '0, '0, 0, 0);
    n_checks++; if (n_err !== 0 || err_code !== 2'd2) begin n_fail++; $display("FAIL err_nop_bad_ch got n=%0d code=%0d want 0 2", n_err, err_code); end
  endtask

  task automatic test_drops_stop();
    logic [N_CH-1:0] en_k1;
    do_cmd(8'h30, '0, '0, '0, 5, 3);
    n_checks++; if (drop_cnt !== 8'd3 || drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL drops_three got %0d want 3", drop_cnt); end
    n_checks++; if (ack_k !== 8 || dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL drops_commit got k=%0d want 8", ack_k); end
    do_cmd(8'h40, '0, '0, '0, 0, 0);
    en_k1 = obs_k1[BW-1 -: N_CH];
    n_checks++; if (en_k1[0] !== 1'b0 || obs_k1 !== exp_k1) begin n_fail++; $display("FAIL stop_at_n2 got en=%b want %b", en_k1, exp_k1[BW-1 -: N_CH]); end
    n_checks++; if (dut_bundle() !== mdl_bundle() || n_ack !== 0 || n_err !== 0) begin n_fail++; $display("FAIL stop_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
  endtask

  task automatic test_drop_saturate();
    for (int i = 0; i < 20; i++) begin
      do_cmd(8'h31, '0, '0, '0, T, 14);
      n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_count[%0d] got %0d want %0d", i, drop_cnt, m_drop); end
    end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned sel, L, n, ch;
      logic [3:0]  op;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       op = 4'h0;
        1, 2:    op = 4'h1;
        3, 4:    op = 4'h2;
        5, 6, 7: op = 4'h3;
        8:       op = 4'h4;
        default: op = 4'($urandom_range(5, 15));
      endcase
      ch = ($urandom_range(0, 4) == 0) ? $urandom_range(N_CH, 15) : $urandom_range(0, N_CH - 1);
      L  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, T + 2);
      n  = 0;
      if (op == 4'h3 && ch < N_CH) n = (L >= 2) ? $urandom_range(0, 3) : $urandom_range(0, 2);
      do_cmd({op, 4'(ch)}, 16'($urandom), 16'($urandom), 8'($urandom), L, n);
      n_checks++; if (n_ack !== ((exp_kind == 1) ? 1 : 0) || ack_k !== ((exp_kind == 1) ? exp_k : 0))
        begin n_fail++; $display("FAIL rand_ack[%0d] op=%h ch=%0d got k=%0d n=%0d want kind=%0d k=%0d", i, op, ch, ack_k, n_ack, exp_kind, exp_k); end
      n_checks++; if (n_err !== ((exp_kind == 2) ? 1 : 0) || err_k !== ((exp_kind == 2) ? exp_k : 0) || (exp_kind == 2 && obs_code !== exp_code))
        begin n_fail++; $display("FAIL rand_err[%0d] op=%h ch=%0d got k=%0d code=%0d want kind=%0d k=%0d code=%0d", i, op, ch, err_k, obs_code, exp_kind, exp_k, exp_code); end
      n_checks++; if (both !== 1'b0 || early_chg !== 1'b0 || obs_k1 !== exp_k1)
        begin n_fail++; $display("FAIL rand_timing[%0d] got both=%b chg=%b k1=%h want 0 0 %h", i, both, early_chg, obs_k1, exp_k1); end
      n_checks++; if (dut_bundle() !== mdl_bundle() || err_code !== m_err || drop_cnt !== 8'(m_drop))
        begin n_fail++; $display("FAIL rand_state[%0d] got %h %0d %0d want %h %0d %0d", i, dut_bundle(), err_code, drop_cnt, mdl_bundle(), m_err, m_drop); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int unsigned acks;
    do_cmd(8'h20, 16'($urandom), '0, 8'($urandom), 0, 0);
    @(negedge sys_clk);
    ch_busy = '1; recv_done = 1'b1; dataA = 8'h30;
    @(negedge sys_clk);
    recv_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    ch_busy = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_reset();
    acks = 0;
    repeat (8) begin
      @(posedge sys_clk); #1;
      if (cfg_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rst_wait_no_ack got %0d want 0", acks); end
    n_checks++; if (dut_bundle() !== mdl_bundle()) begin n_fail++; $display("FAIL rst_wait_outputs got %h want %h", dut_bundle(), mdl_bundle()); end
    n_checks++; if ({cmd_err, err_code, drop_cnt} !== 11'h000) begin n_fail++; $display("FAIL rst_wait_status got %b %0d %0d want 0", cmd_err, err_code, drop_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_start();
    test_timeout();
    test_wait_busy();
    test_errors();
    test_drops_stop();
    test_drop_saturate();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
